// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: state encoding, data width
// and the line level driven while idle or in reset.
package uart_pkg;

  localparam int   DATA_W    = 8;
  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Per-bit clock counter: counts 0..div and strikes bit_end on the last clock
// of each bit. bit_end_nxt predicts the strike one cycle ahead.
module uart_baud_cnt #(
  parameter int P_DIV_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [P_DIV_W-1:0] div,
  output logic               bit_end,
  output logic               bit_end_nxt
);

  logic [P_DIV_W-1:0] count;
  logic [P_DIV_W-1:0] count_nxt;

  assign bit_end = (count == div);

  always_comb begin
    if (clear || bit_end) count_nxt = '0;
    else                  count_nxt = count + P_DIV_W'(1);
  end

  // Lets the owner register outputs that must coincide with the next strike.
  assign bit_end_nxt = (count_nxt == div);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else       count <= count_nxt;
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: pops bytes from the TX FIFO and serialises them as
// start + 8 data (LSB first) + optional parity + 1/2 stop bits on txd.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int P_DIV_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_enable,
  input  logic [P_DIV_W-1:0] baud_div,
  input  logic               parity_en,
  input  logic               parity_odd,
  input  logic               stop2,
  input  logic [DATA_W-1:0]  fifo_rdata,
  input  logic               fifo_empty,
  output logic               fifo_pop,
  output logic               txd,
  output logic               busy,
  output logic               tx_done
);

  tx_state_e          state_q,    state_n;
  logic [DATA_W-1:0]  shift_q,    shift_n;
  logic [2:0]         bit_cnt_q,  bit_cnt_n;
  logic               stop_cnt_q, stop_cnt_n;
  logic               par_q,      par_n;
  logic               par_en_q,   par_en_n;
  logic               stop2_q,    stop2_n;
  logic [P_DIV_W-1:0] div_q,      div_n;

  logic txd_n, busy_n, done_n;
  logic bit_end, bit_end_nxt;
  logic stop_last, frame_end;

  uart_baud_cnt #(.P_DIV_W(P_DIV_W)) u_baud (
    .clk         (clk),
    .reset       (reset),
    .clear       (fifo_pop || (state_n == IDLE)),
    .div         (div_q),
    .bit_end     (bit_end),
    .bit_end_nxt (bit_end_nxt)
  );

  assign stop_last = !stop2_q || stop_cnt_q;
  assign frame_end = (state_q == STOP) && bit_end && stop_last;

  // Loads happen from IDLE or on the final stop clock, giving gap-free frames.
  assign fifo_pop = !reset && tx_enable && !fifo_empty &&
                    ((state_q == IDLE) || frame_end);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case/if tree can leave it unassigned and infer a latch.
    state_n    = state_q;
    shift_n    = shift_q;
    bit_cnt_n  = bit_cnt_q;
    stop_cnt_n = stop_cnt_q;
    par_n      = par_q;
    par_en_n   = par_en_q;
    stop2_n    = stop2_q;
    div_n      = div_q;

    if (fifo_pop) begin
      state_n    = START;
      shift_n    = fifo_rdata;
      par_n      = (^fifo_rdata) ^ parity_odd;
      par_en_n   = parity_en;
      stop2_n    = stop2;
      div_n      = baud_div;
      bit_cnt_n  = 3'd0;
      stop_cnt_n = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        START: if (bit_end) state_n = DATA;
        DATA: begin
          if (bit_end) begin
            shift_n   = shift_q >> 1;
            bit_cnt_n = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_n = par_en_q ? PARITY : STOP;
          end
        end
        PARITY: if (bit_end) state_n = STOP;
        STOP: begin
          if (bit_end) begin
            if (stop_last) state_n    = IDLE;
            else           stop_cnt_n = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Outputs are decoded from next-state values so the registers line up with
  // the state they describe.
  always_comb begin
    txd_n = LINE_IDLE;
    case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = shift_n[0];
      PARITY:  txd_n = par_n;
      default: txd_n = LINE_IDLE;
    endcase
    busy_n = (state_n != IDLE);
    done_n = (state_n == STOP) && (!stop2_n || stop_cnt_n) && bit_end_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      par_q      <= 1'b0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      div_q      <= '0;
      txd        <= LINE_IDLE;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state_q    <= state_n;
      shift_q    <= shift_n;
      bit_cnt_q  <= bit_cnt_n;
      stop_cnt_q <= stop_cnt_n;
      par_q      <= par_n;
      par_en_q   <= par_en_n;
      stop2_q    <= stop2_n;
      div_q      <= div_n;
      txd        <= txd_n;
      busy       <= busy_n;
      tx_done    <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: a frame-level model predicts txd,
// busy, tx_done and fifo_pop every cycle; directed scenarios pin timing.
module tb_uart_tx_engine;

  localparam int P_DIV_W = 16;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               tx_enable = 1'b0;
  logic [P_DIV_W-1:0] baud_div = 16'd3;
  logic               parity_en = 1'b0;
  logic               parity_odd = 1'b0;
  logic               stop2 = 1'b0;
  logic [7:0]         fifo_rdata;
  logic               fifo_empty;
  logic               fifo_pop, txd, busy, tx_done;

  uart_tx_engine #(.P_DIV_W(P_DIV_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_enable  (tx_enable),
    .baud_div   (baud_div),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .stop2      (stop2),
    .fifo_rdata (fifo_rdata),
    .fifo_empty (fifo_empty),
    .fifo_pop   (fifo_pop),
    .txd        (txd),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  // Environment FIFO
  logic [7:0] fifo_mem [16];
  int rd = 0, wr = 0, cyc = 0;
  assign fifo_empty = (rd == wr);
  assign fifo_rdata = fifo_mem[rd % 16];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_pop && rd != wr) rd <= rd + 1;
  end

  int n_total = 0, n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Frame model: slot k of a frame (start, D0..D7, parity, stops)
  function automatic logic frame_bit(input logic [7:0] d, input logic pen,
                                     input logic podd, input int k);
    if (k == 0)             return 1'b0;
    if (k >= 1 && k <= 8)   return d[k-1];
    if (k == 9 && pen)      return (^d) ^ podd;
    return 1'b1;
  endfunction

  function automatic int frame_slots(input logic pen, input logic s2);
    return 10 + int'(pen) + int'(s2);
  endfunction

  typedef struct packed {logic lvl; logic last;} slot_t;
  slot_t exp_q[$];
  int    pop_cyc[$];
  int    done_cyc[$];

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1000000;
  endfunction

  always @(negedge clk) begin : cmp
    slot_t cur, s;
    logic  e_txd, e_busy, e_done, e_pop;
    int    slots, dv;
    if (chk_en) begin
      if (exp_q.size() > 0) begin
        cur    = exp_q.pop_front();
        e_txd  = cur.lvl;
        e_busy = 1'b1;
        e_done = cur.last;
      end else begin
        e_txd  = 1'b1;
        e_busy = 1'b0;
        e_done = 1'b0;
      end
      e_pop = !reset && tx_enable && !fifo_empty && (exp_q.size() == 0);
      check("txd", txd, e_txd);
      check("busy", busy, e_busy);
      check("tx_done", tx_done, e_done);
      check("fifo_pop", fifo_pop, e_pop);
      if (e_pop) begin
        slots = frame_slots(parity_en, stop2);
        dv    = int'(baud_div);
        for (int k = 0; k < slots; k++)
          for (int r = 0; r <= dv; r++) begin
            s.lvl  = frame_bit(fifo_rdata, parity_en, parity_odd, k);
            s.last = (k == slots - 1) && (r == dv);
            exp_q.push_back(s);
          end
      end
      if (reset) exp_q.delete();
      if (fifo_pop) pop_cyc.push_back(cyc);
      if (tx_done)  done_cyc.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr % 16] = b;
    wr = wr + 1;
  endtask

  task automatic drain(input string name, input int max);
    int n = 0;
    while ((exp_q.size() != 0 || rd != wr) && n < max) begin
      tick(1);
      n++;
    end
    check({"drain_", name}, 32'(n < max), 32'd1);
    tick(2);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [9:0] pat;
    int p0, d0;
    for (int i = 0; i < 16; i++) fifo_mem[i] = 8'h00;

    // Pin the frame model against hand-computed values
    for (int k = 0; k < 10; k++) pat[k] = frame_bit(8'hA5, 1'b0, 1'b0, k);
    check("mdl_a5_bits", 32'(pat), 32'h34A);
    check("mdl_a5_len", frame_slots(1'b0, 1'b0) * 4, 40);
    check("mdl_07_even_par", frame_bit(8'h07, 1'b1, 1'b0, 9), 1);
    check("mdl_07_odd_par", frame_bit(8'h07, 1'b1, 1'b1, 9), 0);
    check("mdl_par_len", frame_slots(1'b1, 1'b0), 11);
    check("mdl_stop2_len", frame_slots(1'b0, 1'b1) * 2, 22);

    tick(2);
    chk_en = 1'b1;
    check("rst_txd", txd, 1);
    check("rst_busy", busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_pop", fifo_pop, 0);
    tick(1);
    reset = 1'b0;
    tx_enable = 1'b1;
    tick(2);

    // 8N1, div=3, 0xA5
    p0 = pop_cyc.size(); d0 = done_cyc.size();
    baud_div = 16'd3; parity_en = 1'b0; stop2 = 1'b0;
    push(8'hA5);
    drain("t1", 200);
    check("t1_pops", pop_cyc.size() - p0, 1);
    check("t1_dones", done_cyc.size() - d0, 1);
    check("t1_latency", at(done_cyc, d0) - at(pop_cyc, p0), 40);

    // div=0, even then odd parity, 0x07
    p0 = pop_cyc.size(); d0 = done_cyc.size();
    baud_div = 16'd0; parity_en = 1'b1; parity_odd = 1'b0;
    push(8'h07);
    drain("t2e", 100);
    parity_odd = 1'b1;
    push(8'h07);
    drain("t2o", 100);
    check("t2_pops", pop_cyc.size() - p0, 2);
    check("t2_len_even", at(done_cyc, d0) - at(pop_cyc, p0), 11);
    check("t2_len_odd", at(done_cyc, d0 + 1) - at(pop_cyc, p0 + 1), 11);

    // Back-to-back, stop2, div=1
    p0 = pop_cyc.size(); d0 = done_cyc.size();
    baud_div = 16'd1; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b1;
    push(8'h11); push(8'h22); push(8'h33);
    drain("t3", 200);
    check("t3_pops", pop_cyc.size() - p0, 3);
    check("t3_first", at(done_cyc, d0) - at(pop_cyc, p0), 22);
    check("t3_period1", at(done_cyc, d0 + 1) - at(done_cyc, d0), 22);
    check("t3_period2", at(done_cyc, d0 + 2) - at(done_cyc, d0 + 1), 22);
    check("t3_nogap", at(pop_cyc, p0 + 1) - at(done_cyc, d0), 0);

    // Empty FIFO, then disabled with data waiting
    stop2 = 1'b0; baud_div = 16'd2;
    p0 = pop_cyc.size();
    tick(100);
    check("t4_empty_pops", pop_cyc.size() - p0, 0);
    tx_enable = 1'b0;
    push(8'h3C);
    tick(20);
    check("t4_disabled_pops", pop_cyc.size() - p0, 0);
    check("t4_held", wr - rd, 1);
    tx_enable = 1'b1;
    drain("t4", 100);
    check("t4_pops", pop_cyc.size() - p0, 1);

    // baud_div change mid-frame
    p0 = pop_cyc.size(); d0 = done_cyc.size();
    baud_div = 16'd3;
    push(8'h5A); push(8'hC3);
    tick(12);
    baud_div = 16'd7;
    drain("t5", 400);
    check("t5_first", at(done_cyc, d0) - at(pop_cyc, p0), 40);
    check("t5_second", at(done_cyc, d0 + 1) - at(done_cyc, d0), 80);

    // Reset during D3, then normal transmission
    p0 = pop_cyc.size(); d0 = done_cyc.size();
    baud_div = 16'd3;
    push(8'h96);
    tick(18);
    reset = 1'b1;
    tick(1);
    check("t6_txd", txd, 1);
    check("t6_busy", busy, 0);
    reset = 1'b0;
    push(8'h4B);
    drain("t6", 200);
    check("t6_pops", pop_cyc.size() - p0, 2);
    check("t6_dones", done_cyc.size() - d0, 1);
    check("t6_len", at(done_cyc, d0) - at(pop_cyc, p0 + 1), 40);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
